// File: rtl/diagonal_walk_ctrl.sv
// Diagonal-order walker over the lower triangle (x >= y) of a square grid.
// Emits one (x, y) pair per valid/ready beat, with done/count/prop status.
module diagonal_walk_ctrl #(
  parameter int W  = 4,
  parameter int CW = 2 * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  kmax,
  input  logic          abort,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          prop
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   x, y, d, k;
  logic [W-1:0]   x_n, y_n, d_n, k_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           accept;
  logic [W-1:0]   span;

  assign accept = (state == RUN) && out_ready;
  assign span   = k - d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      d     <= '0;
      k     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      d     <= d_n;
      k     <= k_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    d_n     = d;
    k_n     = k;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          k_n     = kmax;
          x_n     = '0;
          y_n     = '0;
          d_n     = '0;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (accept) begin
          cnt_n = cnt + CW'(1);
          // d <= k always holds, so span and the +1 steps never wrap
          if (y < span) begin
            x_n = x + W'(1);
            y_n = y + W'(1);
          end else if (d < k) begin
            d_n = d + W'(1);
            x_n = d + W'(1);
            y_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_last  = (state == RUN) && (d == k) && (y == '0);
  assign out_x     = x;
  assign out_y     = y;
  assign count     = cnt;
  assign prop      = !(x < y);

endmodule

// File: tb/tb_diagonal_walk_ctrl.sv
// Directed bench for diagonal_walk_ctrl: table of walks plus
// hand-written abort and mid-walk reset sequences.
module tb_diagonal_walk_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] kmax;
  logic       abort;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [7:0] count;
  logic       prop;

  int tests;
  int failed;
  int obs_x[$];
  int obs_y[$];

  typedef struct {
    int k;
    bit stall;
    bit disturb;
    int total;
    int last_x;
  } vec_t;

  vec_t vecs[5];

  diagonal_walk_ctrl #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kmax      (kmax),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .prop      (prop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_walk(input int k, input bit stall,
                          input bit disturb, output int acc);
    int  ex[$];
    int  ey[$];
    bit  fin;
    int  cyc;
    int  lx;
    int  ly;
    for (int dd = 0; dd <= k; dd++)
      for (int yy = 0; yy <= k - dd; yy++) begin
        ex.push_back(yy + dd);
        ey.push_back(yy);
      end
    obs_x.delete();
    obs_y.delete();
    acc = 0;
    fin = 0;
    cyc = 0;
    lx  = -1;
    ly  = -1;
    @(negedge clk);
    kmax      = 4'(k);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 1000 && !fin) begin
      if (done) begin
        fin = 1;
        check("done_count", count, ex.size());
        check("done_last_x", out_x, lx);
        check("done_last_y", out_y, ly);
      end else begin
        check("busy", busy, 1);
        check("valid", out_valid, 1);
        check("count", count, acc);
        check("x", out_x, ex[acc]);
        check("y", out_y, ey[acc]);
        check("last", out_last, (acc == ex.size() - 1));
        check("prop", prop, 1);
        start = disturb && acc >= 3 && acc <= 8;
        kmax  = disturb ? 4'd1 : 4'(k);
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          obs_x.push_back(int'(out_x));
          obs_y.push_back(int'(out_y));
          lx = int'(out_x);
          ly = int'(out_y);
          acc++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) check("walk_timeout", 0, 1);
    start     = 1'b0;
    out_ready = 1'b1;
    check("done_pulse_once", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_last", out_last, 0);
  endtask

  initial begin
    int acc;
    int hx[6];
    int hy[6];
    int kx[3];
    int ky[3];
    tests     = 0;
    failed    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    kmax      = '0;
    abort     = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{k: 0,  stall: 0, disturb: 0, total: 1,   last_x: 0};
    vecs[1] = '{k: 2,  stall: 0, disturb: 0, total: 6,   last_x: 2};
    vecs[2] = '{k: 3,  stall: 1, disturb: 0, total: 10,  last_x: 3};
    vecs[3] = '{k: 15, stall: 0, disturb: 0, total: 136, last_x: 15};
    vecs[4] = '{k: 5,  stall: 0, disturb: 1, total: 21,  last_x: 5};
    hx = '{0, 1, 2, 1, 2, 2};
    hy = '{0, 1, 2, 0, 1, 0};
    kx = '{0, 1, 1};
    ky = '{0, 1, 0};

    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    check("rst_last", out_last, 0);
    check("rst_prop", prop, 1);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_walk(vecs[i].k, vecs[i].stall, vecs[i].disturb, acc);
      check("accepts", acc, vecs[i].total);
      check("final_x", out_x, vecs[i].last_x);
      check("final_y", out_y, 0);
      check("final_count", count, vecs[i].total);
      if (vecs[i].k == 2) begin
        check("k2_len", obs_x.size(), 6);
        for (int j = 0; j < 6 && j < obs_x.size(); j++) begin
          check("k2_seq_x", obs_x[j], hx[j]);
          check("k2_seq_y", obs_y[j], hy[j]);
        end
      end
    end

    // abort after 5 accepts of a K=4 walk
    @(negedge clk);
    kmax      = 4'd4;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ab_count", count, 5);
    check("ab_x", out_x, 1);
    check("ab_y", out_y, 0);
    check("ab_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    check("ab_idle_busy", busy, 0);
    check("ab_idle_valid", out_valid, 0);
    check("ab_no_done", done, 0);
    check("ab_hold_count", count, 5);
    check("ab_hold_x", out_x, 1);
    check("ab_hold_y", out_y, 0);
    start = 1'b1;
    @(negedge clk);
    check("ab_over_start", busy, 0);
    check("ab_still_no_done", done, 0);
    start = 1'b0;
    abort = 1'b0;

    run_walk(1, 0, 0, acc);
    check("k1_accepts", acc, 3);
    check("k1_len", obs_x.size(), 3);
    for (int j = 0; j < 3 && j < obs_x.size(); j++) begin
      check("k1_seq_x", obs_x[j], kx[j]);
      check("k1_seq_y", obs_y[j], ky[j]);
    end

    // asynchronous reset in the middle of a K=5 walk
    @(negedge clk);
    kmax  = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_x", out_x, 0);
    check("mid_rst_y", out_y, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_prop", prop, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
